// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, starvation limit and write-source tag for the regfile write-port arbiter
package regfile_wb_arbiter_pkg;
    localparam int RF_DSIZE = 32;
    localparam int RF_ASIZE = 5;
    localparam int RF_ISIZE = 32;
    localparam int RF_MAX_WAIT = 4;
    typedef enum logic {SRC_WB, SRC_MDU} wr_src_e;
endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_result_fifo: 2-entry circular FIFO of pending MDU {waddr, wdata} regfile writes
module wb_result_fifo import regfile_wb_arbiter_pkg::*; #(
    parameter int DSIZE = RF_DSIZE,
    parameter int ASIZE = RF_ASIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [ASIZE-1:0]      push_waddr_i,
    input  logic [DSIZE-1:0]      push_wdata_i,
    input  logic                  pop_i,
    output logic [1:0]            count_o,
    output logic [ASIZE-1:0]      head_waddr_o,
    output logic [DSIZE-1:0]      head_wdata_o,
    output logic [1:0][ASIZE-1:0] ent_waddr_o,
    output logic [1:0]            ent_valid_o
);
    logic [1:0][ASIZE-1:0] waddr_q, waddr_d;
    logic [1:0][DSIZE-1:0] wdata_q, wdata_d;
    logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    always_comb begin
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (push_i) begin
            waddr_d[wr_ptr_q] = push_waddr_i;
            wdata_d[wr_ptr_q] = push_wdata_i;
        end
        wr_ptr_d = wr_ptr_q ^ push_i;
        rd_ptr_d = rd_ptr_q ^ pop_i;
        count_d  = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr_q  <= '0;
            wdata_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_waddr_o = waddr_q[rd_ptr_q];
    assign head_wdata_o = wdata_q[rd_ptr_q];
    assign ent_waddr_o  = waddr_q;
    // With one entry stored, only the slot under the read pointer is live
    assign ent_valid_o  = {count_q == 2'd2 || (count_q == 2'd1 && rd_ptr_q),
                           count_q == 2'd2 || (count_q == 2'd1 && !rd_ptr_q)};
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between pipeline writeback (priority) and buffered MDU results
module regfile_wb_arbiter import regfile_wb_arbiter_pkg::*; #(
    parameter int DSIZE    = RF_DSIZE,
    parameter int ASIZE    = RF_ASIZE,
    parameter int ISIZE    = RF_ISIZE,
    parameter int MAX_WAIT = RF_MAX_WAIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_wen_i,
    input  logic             wb_mem_to_reg_i,
    input  logic [DSIZE-1:0] wb_result_i,
    input  logic [DSIZE-1:0] wb_rdata_mem_i,
    input  logic [ASIZE-1:0] wb_waddr_i,
    input  logic             wb_jal_i,
    input  logic [ISIZE-1:0] wb_pc_jal_i,
    input  logic             mdu_valid_i,
    input  logic [ASIZE-1:0] mdu_waddr_i,
    input  logic [DSIZE-1:0] mdu_wdata_i,
    output logic             mdu_ready_o,
    input  logic [ASIZE-1:0] rs1_addr_i,
    input  logic [ASIZE-1:0] rs2_addr_i,
    output logic             mdu_hazard_o,
    output logic             stall_pipe_o,
    output logic             rf_wen_o,
    output logic [ASIZE-1:0] rf_waddr_o,
    output logic [DSIZE-1:0] rf_wdata_o,
    output logic             grant_mdu_o
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [1:0]            count;
    logic [ASIZE-1:0]      head_waddr;
    logic [DSIZE-1:0]      head_wdata, wb_wdata;
    logic [1:0][ASIZE-1:0] ent_waddr;
    logic [1:0]            ent_valid;
    logic                  wb_req, push, hazard;
    wr_src_e               src;
    logic [WW-1:0]         wait_q, wait_d;

    wb_result_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_waddr_i (mdu_waddr_i),
        .push_wdata_i (mdu_wdata_i),
        .pop_i        (grant_mdu_o),
        .count_o      (count),
        .head_waddr_o (head_waddr),
        .head_wdata_o (head_wdata),
        .ent_waddr_o  (ent_waddr),
        .ent_valid_o  (ent_valid)
    );

    // rst gates the pipeline request so the port is quiet while reset is held
    assign wb_req       = !rst && wb_wen_i && wb_waddr_i != '0;
    assign wb_wdata     = wb_jal_i ? DSIZE'(wb_pc_jal_i) : wb_mem_to_reg_i ? wb_rdata_mem_i : wb_result_i;
    assign src          = (!wb_req && count != 2'd0) ? SRC_MDU : SRC_WB;
    assign grant_mdu_o  = src == SRC_MDU;
    assign rf_wen_o     = wb_req || grant_mdu_o;
    assign rf_waddr_o   = grant_mdu_o ? head_waddr : wb_waddr_i;
    assign rf_wdata_o   = grant_mdu_o ? head_wdata : wb_wdata;
    assign mdu_ready_o  = count != 2'd2;
    assign push         = mdu_valid_i && mdu_ready_o && mdu_waddr_i != '0;
    assign mdu_hazard_o = hazard;
    assign stall_pipe_o = wait_q >= WW'(MAX_WAIT) && !grant_mdu_o;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 2; i++)
            hazard = hazard || (ent_valid[i] && ((rs1_addr_i != '0 && ent_waddr[i] == rs1_addr_i) ||
                                                 (rs2_addr_i != '0 && ent_waddr[i] == rs2_addr_i)));
        wait_d = (grant_mdu_o || count == 2'd0) ? '0 : (wait_q < WW'(MAX_WAIT)) ? wait_q + 1'b1 : wait_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_q <= '0;
        else
            wait_q <= wait_d;
    end
endmodule
